// File: rtl/audio_pkg.sv
// Shared definitions for the audio output chain: capture FSM encoding and
// frame geometry helpers.
package audio_pkg;

    typedef logic [1:0] cap_state_t;

    localparam cap_state_t ST_WAIT  = 2'd0;
    localparam cap_state_t ST_ACK   = 2'd1;
    localparam cap_state_t ST_DRAIN = 2'd2;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_CLK_DIV    = 4;

    // One I2S frame carries a left and a right slot of data_width bits each.
    function automatic int frame_len(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit/word clock generator: divides clk into BCLK, tracks the bit
// position within the frame and strobes on BCLK falling events.
module i2s_clock_gen
    import audio_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int clk_div    = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic o_bclk,
    output logic o_lrclk,
    output logic o_fall,
    output logic o_load
);

    localparam int FRAME = frame_len(data_width);
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = $clog2(clk_div);

    localparam logic [DW-1:0] DIV_TC = DW'(clk_div - 1);
    localparam logic [BW-1:0] BIT_TC = BW'(FRAME - 1);
    localparam logic [BW-1:0] HALF   = BW'(data_width);

    logic [DW-1:0] r_div_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [BW-1:0] w_bit_nxt;
    logic          r_bclk;
    logic          r_lrclk;
    logic          w_tc;
    logic          w_fall;

    assign w_tc      = (r_div_cnt == DIV_TC);
    assign w_fall    = w_tc & r_bclk;
    assign w_bit_nxt = (r_bit_cnt == BIT_TC) ? '0 : r_bit_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
        end else begin
            if (w_tc) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
            // Word select and bit position only move on BCLK falling events.
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= (w_bit_nxt >= HALF);
            end
        end
    end

    assign o_bclk  = r_bclk;
    assign o_lrclk = r_lrclk;
    assign o_fall  = w_fall;
    // Load fires as bit_cnt becomes 1: the one-BCLK I2S data delay.
    assign o_load  = w_fall & (r_bit_cnt == '0);

endmodule

// File: rtl/i2s_tx_sink.sv
// Terminal audio sink: captures mono samples over a valid/done handshake and
// transmits each as an I2S frame with the sample on both slots.
module i2s_tx_sink
    import audio_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int clk_div    = DEFAULT_CLK_DIV
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [data_width-1:0] i_data,
    input  logic                         i_data_valid,
    output logic                         o_read_done,
    output logic                         o_bclk,
    output logic                         o_lrclk,
    output logic                         o_sdata,
    output logic                         o_underrun
);

    localparam int FRAME = frame_len(data_width);

    cap_state_t                  r_state;
    cap_state_t                  w_state_nxt;
    logic                        w_capture;
    logic                        w_ack;
    logic                        w_fall;
    logic                        w_load;
    logic                        r_full;
    logic signed [data_width-1:0] r_hold;
    logic signed [data_width-1:0] r_last;
    logic signed [data_width-1:0] w_sample;
    logic [FRAME-1:0]            r_shift;
    logic                        r_read_done;
    logic                        r_underrun;

    i2s_clock_gen #(
        .data_width (data_width),
        .clk_div    (clk_div)
    ) u_clock_gen (
        .clk     (clk),
        .reset   (reset),
        .o_bclk  (o_bclk),
        .o_lrclk (o_lrclk),
        .o_fall  (w_fall),
        .o_load  (w_load)
    );

    assign w_capture = (r_state == ST_WAIT) & ~r_full & i_data_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT:  if (w_capture) w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_DRAIN;
            // Upstream registers its valid, so it may linger after the ack.
            ST_DRAIN: if (!i_data_valid) w_state_nxt = ST_WAIT;
            default:  w_state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        w_ack = (r_state == ST_ACK);
    end

    assign w_sample = r_full ? r_hold : r_last;

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_hold <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full      <= 1'b0;
            r_last      <= '0;
            r_shift     <= '0;
            r_read_done <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_read_done <= w_ack;
            r_underrun  <= w_load & ~r_full;
            // Capture needs an empty holding register, so it never collides
            // with the load draining a full one.
            if (w_capture) begin
                r_full <= 1'b1;
                r_last <= i_data;
            end else if (w_load) begin
                r_full <= 1'b0;
            end
            if (w_load) begin
                r_shift <= {w_sample, w_sample};
            end else if (w_fall) begin
                r_shift <= {r_shift[FRAME-2:0], 1'b0};
            end
        end
    end

    assign o_read_done = r_read_done;
    assign o_underrun  = r_underrun;
    assign o_sdata     = r_shift[FRAME-1];

endmodule

// File: tb/tb_i2s_tx_sink.sv
// Bench for i2s_tx_sink: lockstep comparison against a frame-timing model
// derived from clock counts, plus scenario-specific checks.
module tb_i2s_tx_sink;

    localparam int DW   = 16;
    localparam int CD   = 2;
    localparam int FCLK = 2 * DW * 2 * CD;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic signed [DW-1:0] i_data = '0;
    logic                 i_data_valid = 1'b0;
    logic                 o_read_done;
    logic                 o_bclk;
    logic                 o_lrclk;
    logic                 o_sdata;
    logic                 o_underrun;

    int n_cmp  = 0;
    int n_fail = 0;

    i2s_tx_sink #(.data_width(DW), .clk_div(CD)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_read_done  (o_read_done),
        .o_bclk       (o_bclk),
        .o_lrclk      (o_lrclk),
        .o_sdata      (o_sdata),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: everything derives from t = clk edges since reset.
    int          t = 0;
    logic        m_full = 1'b0;
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] m_last = '0;
    logic        m_low_seen = 1'b1;
    int          m_cap_edge = -10;
    logic        m_cap_prev = 1'b0;
    logic [2*DW-1:0] m_word = '0;
    int          m_j = 0;
    logic        m_loaded = 1'b0;
    logic        e_bclk = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_ur = 1'b0, e_rd = 1'b0;

    always @(posedge clk) begin
        logic fall, load, cap;
        int bitc;
        logic [DW-1:0] s;
        if (!reset) begin
            t = 0; m_full = 1'b0; m_last = '0; m_low_seen = 1'b1; m_cap_edge = -10;
            m_cap_prev = 1'b0; m_word = '0; m_j = 0; m_loaded = 1'b0;
            e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_ur = 1'b0; e_rd = 1'b0;
        end else begin
            t++;
            fall = ((t % (2 * CD)) == 0);
            bitc = (t / (2 * CD)) % (2 * DW);
            load = fall && (bitc == 1);
            e_rd = m_cap_prev;
            cap  = m_low_seen && !m_full && i_data_valid;
            e_ur = load && !m_full;
            if (load) begin
                s = m_full ? m_hold : m_last;
                m_full = 1'b0;
                m_word = {s, s};
                m_j = 0;
                m_loaded = 1'b1;
            end else if (fall && m_loaded) begin
                m_j++;
            end
            if (cap) begin
                m_full = 1'b1; m_hold = i_data; m_last = i_data;
                m_low_seen = 1'b0; m_cap_edge = t;
            end else if (!i_data_valid && t >= m_cap_edge + 2) begin
                m_low_seen = 1'b1;
            end
            m_cap_prev = cap;
            e_bclk = ((t / CD) % 2) == 1;
            e_lr   = (bitc >= DW);
            e_sd   = m_loaded ? m_word[2*DW-1-m_j] : 1'b0;
        end
    end

    // One clk cycle: sample at negedge and compare all outputs to the model.
    task automatic advance(output logic rd, output logic ur);
        @(negedge clk);
        n_cmp++;
        if ({o_bclk, o_lrclk, o_sdata, o_underrun, o_read_done} !==
            {e_bclk, e_lr, e_sd, e_ur, e_rd}) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL outputs t=%0d {bclk,lrclk,sdata,underrun,read_done} got %b want %b",
                         t, {o_bclk, o_lrclk, o_sdata, o_underrun, o_read_done},
                         {e_bclk, e_lr, e_sd, e_ur, e_rd});
        end
        rd = o_read_done;
        ur = o_underrun;
    endtask

    task automatic drive_sample(input logic [DW-1:0] d, input int hold,
                                output int lat, output int rdc, output int urc);
        logic rd, ur;
        i_data = d;
        i_data_valid = 1'b1;
        lat = -1; rdc = 0; urc = 0;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            advance(rd, ur);
            urc += int'(ur);
            if (rd) begin lat = c; rdc++; end
        end
        if (lat < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL read_done_timeout got none want pulse within 400 clk");
        end
        repeat (hold) begin
            advance(rd, ur);
            urc += int'(ur);
            rdc += int'(rd);
        end
        i_data_valid = 1'b0;
    endtask

    task automatic align(input int phase, output int urc, output int rdc);
        logic rd, ur;
        logic done;
        urc = 0; rdc = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            advance(rd, ur);
            urc += int'(ur);
            rdc += int'(rd);
            if ((t % FCLK) == phase) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL align_timeout got none want phase %0d", phase);
        end
    endtask

    task automatic test_reset();
        logic rd, ur, pb, pl;
        int urc, brise, lrise, ones;
        reset = 1'b0; i_data_valid = 1'b0;
        repeat (3) begin
            advance(rd, ur);
            n_cmp++;
            if ({o_bclk, o_lrclk, o_sdata, o_underrun, o_read_done} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_values got %b want 00000",
                         {o_bclk, o_lrclk, o_sdata, o_underrun, o_read_done});
            end
        end
        reset = 1'b1;
        urc = 0; brise = 0; lrise = 0; ones = 0; pb = 1'b0; pl = 1'b0;
        repeat (2 * FCLK) begin
            advance(rd, ur);
            urc += int'(ur);
            if (o_bclk && !pb) brise++;
            if (o_lrclk && !pl) lrise++;
            ones += int'(o_sdata);
            pb = o_bclk; pl = o_lrclk;
        end
        n_cmp++;
        if (urc != 2) begin n_fail++; $display("FAIL idle_underruns got %0d want 2", urc); end
        n_cmp++;
        if (brise != 64) begin n_fail++; $display("FAIL bclk_rises got %0d want 64", brise); end
        n_cmp++;
        if (lrise != 2) begin n_fail++; $display("FAIL lrclk_rises got %0d want 2", lrise); end
        n_cmp++;
        if (ones != 0) begin n_fail++; $display("FAIL idle_sdata_ones got %0d want 0", ones); end
    endtask

    task automatic test_single();
        int lat, rdc, urc, u, r;
        drive_sample(16'h8001, 0, lat, rdc, urc);
        n_cmp++;
        if (lat != 2) begin n_fail++; $display("FAIL single_latency got %0d want 2", lat); end
        n_cmp++;
        if (rdc != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", rdc); end
        align(10, u, r);
        align(10, u, r);
    endtask

    task automatic test_hold_valid();
        int lat, rdc, urc, u, r;
        drive_sample(16'h1234, 5, lat, rdc, urc);
        n_cmp++;
        if (rdc != 1) begin n_fail++; $display("FAIL held_valid_pulses got %0d want 1", rdc); end
        align(10, u, r);
        n_cmp++;
        if (r != 0) begin n_fail++; $display("FAIL after_drop_pulses got %0d want 0", r); end
        align(10, u, r);
    endtask

    task automatic test_each_frame();
        int lat, rdc, urc, u1, u2, r;
        align(10, u1, r);
        drive_sample(16'h7FFF, 0, lat, rdc, urc);
        align(10, u1, r);
        drive_sample(16'hFFFF, 0, lat, rdc, u2);
        u1 += u2;
        align(10, u2, r);
        n_cmp++;
        if (u1 + u2 + urc != 0) begin
            n_fail++; $display("FAIL fed_underruns got %0d want 0", u1 + u2 + urc);
        end
    endtask

    task automatic test_underrun();
        int lat, rdc, urc, u1, u2, r;
        drive_sample(16'h0F0F, 0, lat, rdc, urc);
        align(10, u1, r);
        n_cmp++;
        if (u1 + urc != 0) begin n_fail++; $display("FAIL fed_frame_underrun got %0d want 0", u1 + urc); end
        align(10, u2, r);
        n_cmp++;
        if (u2 != 1) begin n_fail++; $display("FAIL starved_underrun got %0d want 1", u2); end
    endtask

    task automatic test_simultaneous();
        int lat, rdc, urc, u, r;
        align(3, u, r);
        drive_sample(DW'($urandom), 0, lat, rdc, urc);
        n_cmp++;
        if (urc != 1) begin n_fail++; $display("FAIL simult_underrun got %0d want 1", urc); end
        n_cmp++;
        if (lat != 2) begin n_fail++; $display("FAIL simult_latency got %0d want 2", lat); end
        align(10, u, r);
        align(10, u, r);
        n_cmp++;
        if (u != 0) begin n_fail++; $display("FAIL simult_next_underrun got %0d want 0", u); end
    endtask

    task automatic test_reset_mid();
        int lat, rdc, urc, u, r;
        logic rd, ur;
        align(10, u, r);
        drive_sample(DW'($urandom), 0, lat, rdc, urc);
        align(60, u, r);
        reset = 1'b0;
        advance(rd, ur);
        n_cmp++;
        if ({o_bclk, o_lrclk, o_sdata, o_underrun, o_read_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_values got %b want 00000",
                     {o_bclk, o_lrclk, o_sdata, o_underrun, o_read_done});
        end
        reset = 1'b1;
        align(10, u, r);
        n_cmp++;
        if (u != 1) begin n_fail++; $display("FAIL midreset_underrun got %0d want 1", u); end
    endtask

    task automatic test_random();
        int lat, rdc, urc, gap, hold;
        logic rd, ur;
        for (int i = 0; i < 10; i++) begin
            gap = $urandom_range(0, 200);
            repeat (gap) advance(rd, ur);
            hold = $urandom_range(0, 6);
            drive_sample(DW'($urandom), hold, lat, rdc, urc);
            n_cmp++;
            if (rdc != 1) begin n_fail++; $display("FAIL random_pulses[%0d] got %0d want 1", i, rdc); end
        end
        repeat (2 * FCLK) advance(rd, ur);
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_valid();
        test_each_frame();
        test_underrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
